// File: rtl/serial_sub.sv
// Bit-serial subtractor computing a - b - bin one bit per clock, LSB first,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic             d_s;
    logic             br_s;
    logic             last_s;
    logic             load_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // Full-subtractor on the current LSBs and next-state selection.
    always_comb begin
        d_s     = fs_diff(a_r[0], b_r[0], br_r);
        br_s    = fs_borrow(a_r[0], b_r[0], br_r);
        last_s  = (cnt_r == LAST);
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, handshake flags and serial datapath; results commit only on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == RUN);
            done    <= (state_s == DONE);
            if (load_s) begin
                a_r   <= a;
                b_r   <= b;
                br_r  <= bin;
                cnt_r <= '0;
                res_r <= '0;
            end else if (state_r == RUN) begin
                a_r   <= a_r >> 1;
                b_r   <= b_r >> 1;
                br_r  <= br_s;
                cnt_r <= cnt_r + CW'(1);
                res_r <= {d_s, res_r[WIDTH-1:1]};
                if (last_s) begin
                    diff <= {d_s, res_r[WIDTH-1:1]};
                    bout <= br_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: cycle-level arithmetic model plus
// directed literal checks on a 4-bit and an 8-bit instance.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       bin = 1'b0;
    logic [3:0] diff;
    logic       bout, busy, done;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'd0;
    logic [7:0] b8 = 8'd0;
    logic       bin8 = 1'b0;
    logic [7:0] diff8;
    logic       bout8, busy8, done8;

    int checks = 0;
    int errors = 0;

    // model state
    int         rem = 0;
    bit         mvalid = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_diff = 4'd0;
    logic       m_bout = 1'b0;
    logic [3:0] p_diff = 4'd0;
    logic       p_bout = 1'b0;

    serial_sub #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .diff(diff), .bout(bout), .busy(busy), .done(done)
    );

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request finishes 4 edges later with plain unsigned arithmetic.
    always @(posedge clk) begin
        int ia, ib, ibn;
        if (!rst_n) begin
            rem = 0; m_done = 1'b0; m_diff = 4'd0; m_bout = 1'b0; mvalid = 1'b1;
        end else if (rem > 0) begin
            m_done = 1'b0;
            rem--;
            if (rem == 0) begin
                m_done = 1'b1; m_diff = p_diff; m_bout = p_bout;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                ia = int'(a); ib = int'(b); ibn = int'(bin);
                p_bout = (ia < ib + ibn);
                p_diff = 4'((ia - ib - ibn + 32) % 16);
                rem = 4;
            end
        end
    end

    // Compare the 4-bit DUT with the model every cycle.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_busy", {31'd0, busy}, {31'd0, rem > 0});
            chk("m_done", {31'd0, done}, {31'd0, m_done});
            chk("m_diff", {28'd0, diff}, {28'd0, m_diff});
            chk("m_bout", {31'd0, bout}, {31'd0, m_bout});
        end
    end

    task automatic issue(input logic [3:0] ta, input logic [3:0] tbv, input logic tbin,
                         output int nb, output bit got);
        a = ta; b = tbv; bin = tbin; start = 1'b1;
        nb = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
            else if (busy) nb++;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input logic tbin,
                          input logic [3:0] ed, input logic eb);
        int nb;
        bit got;
        issue(ta, tbv, tbin, nb, got);
        chk("busy_cycles", nb, 32'd4);
        chk("lit_diff", {28'd0, diff}, {28'd0, ed});
        chk("lit_bout", {31'd0, bout}, {31'd0, eb});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, nd, last, cyc, ngap;
        bit got;
        logic [3:0] cap;

        repeat (3) @(negedge clk);
        chk("rst_diff", {28'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0);
        run_op(4'b0010, 4'b0101, 1'b0, 4'b1101, 1'b1);
        run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
        run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
        run_op(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0);
        run_op(4'b1000, 4'b0001, 1'b1, 4'b0110, 1'b0);

        // start pulsed while busy must be ignored
        @(negedge clk);
        a = 4'b0011; b = 4'b0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'b1111; b = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; cap = 4'hx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin nd++; cap = diff; end
        end
        chk("ign_ndone", nd, 32'd1);
        chk("ign_diff", {28'd0, cap}, 32'd2);

        // start held high: back-to-back ops, done every 5 cycles
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        nd = 0; last = -1; cyc = 0; ngap = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                nd++;
                chk("b2b_diff", {28'd0, diff}, 32'd5);
                if (last >= 0) begin
                    chk("b2b_gap", cyc - last, 32'd5);
                    ngap++;
                end
                last = cyc;
            end
        end
        chk("b2b_ndone", nd, 32'd4);
        chk("b2b_ngap", ngap, 32'd3);
        start = 1'b0;
        for (int i = 0; i < 10 && (busy || done); i++) @(negedge clk);
        chk("b2b_idle", {31'd0, busy | done}, 32'd0);

        // reset asserted during the second RUN cycle aborts the op
        @(negedge clk);
        a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {28'd0, diff}, 32'd0);
        chk("abort_bout", {31'd0, bout}, 32'd0);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_nodone", nd, 32'd0);

        // exhaustive 4-bit sweep; the model compare checks each result
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    issue(4'(ia), 4'(ib), 1'(ic), nb, got);

        // 8-bit instance
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
        nb = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) got = 1'b1;
            else if (busy8) nb++;
        end
        chk("w8_got", {31'd0, got}, 32'd1);
        chk("w8_busy", nb, 32'd8);
        chk("w8_diff", {24'd0, diff8}, 32'd254);
        chk("w8_bout", {31'd0, bout8}, 32'd0);

        @(negedge clk);
        a8 = 8'd0; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) got = 1'b1;
        end
        chk("w8b_got", {31'd0, got}, 32'd1);
        chk("w8b_diff", {24'd0, diff8}, 32'd255);
        chk("w8b_bout", {31'd0, bout8}, 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
